// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller definitions: debounce FSM states and lamp bit indices.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } debounce_state_e;

  localparam int LAMP_GREEN  = 0;
  localparam int LAMP_YELLOW = 1;
  localparam int LAMP_RED    = 2;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus level debouncer for the farm-road loop sensor.
// state   | meaning
// IDLE_LO | no vehicle, stable low
// CHK_HI  | counting consecutive high samples
// IDLE_HI | vehicle present, stable high
// CHK_LO  | counting consecutive low samples
module sensor_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensor_raw,
  output logic level,
  output logic arrival
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic s1, s2;
  debounce_state_e state, next_state;
  logic [CW-1:0] cnt, next_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= IDLE_LO;
      cnt   <= '0;
    end else begin
      s1    <= sensor_raw;
      s2    <= s1;
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    arrival    = 1'b0;
    case (state)
      IDLE_LO: if (s2) begin
        if (DEBOUNCE_CYCLES == 1) begin
          next_state = IDLE_HI;
          next_cnt   = '0;
          arrival    = 1'b1;
        end else begin
          next_state = CHK_HI;
          next_cnt   = CW'(1);
        end
      end
      CHK_HI: begin
        if (!s2) begin
          next_state = IDLE_LO;
          next_cnt   = '0;
        end else if (cnt == LAST) begin
          next_state = IDLE_HI;
          next_cnt   = '0;
          arrival    = 1'b1;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      IDLE_HI: if (!s2) begin
        if (DEBOUNCE_CYCLES == 1) begin
          next_state = IDLE_LO;
          next_cnt   = '0;
        end else begin
          next_state = CHK_LO;
          next_cnt   = CW'(1);
        end
      end
      CHK_LO: begin
        if (s2) begin
          next_state = IDLE_HI;
          next_cnt   = '0;
        end else if (cnt == LAST) begin
          next_state = IDLE_LO;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + CW'(1);
        end
      end
      default: begin
        next_state = IDLE_LO;
        next_cnt   = '0;
      end
    endcase
  end

  assign level = (state == IDLE_HI) || (state == CHK_LO);

endmodule

// File: rtl/farm_sensor_cond.sv
// Farm-road vehicle request conditioner: debounced arrivals, waiting-car counter, request hold.
// Optional stuck-sensor detector enabled by defining SENSOR_STUCK_DET_EN.
module farm_sensor_cond
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int STUCK_CYCLES    = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sensor_raw,
  input  logic             farm_green,
  output logic             car_req,
  output logic             car_pulse,
  output logic [CNT_W-1:0] car_count,
  output logic             overflow,
  output logic             sensor_fault
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic sensor_level, arr;
  logic [CNT_W-1:0] next_count;
  logic next_ovf, req_force;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (sensor_raw),
    .level      (sensor_level),
    .arrival    (arr)
  );

  // A green grant serves the whole queue; arrivals seen during green are not queued.
  always_comb begin
    next_count = car_count;
    next_ovf   = overflow;
    if (farm_green) begin
      next_count = '0;
      next_ovf   = 1'b0;
    end else if (arr) begin
      if (car_count == CNT_MAX) next_ovf = 1'b1;
      else next_count = car_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_count <= '0;
      overflow  <= 1'b0;
      car_pulse <= 1'b0;
      car_req   <= 1'b0;
    end else begin
      car_count <= next_count;
      overflow  <= next_ovf;
      car_pulse <= arr;
      car_req   <= (next_count != '0) | req_force;
    end
  end

`ifdef SENSOR_STUCK_DET_EN
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  logic [SW-1:0] stuck_cnt;
  logic fault_next;

  assign fault_next = sensor_fault | (sensor_level && (stuck_cnt == SW'(STUCK_CYCLES - 1)));
  assign req_force  = fault_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stuck_cnt    <= '0;
      sensor_fault <= 1'b0;
    end else begin
      if (!sensor_level) stuck_cnt <= '0;
      else if (stuck_cnt != SW'(STUCK_CYCLES)) stuck_cnt <= stuck_cnt + SW'(1);
      sensor_fault <= fault_next;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = sensor_level ^ (STUCK_CYCLES > 0);
  assign req_force    = 1'b0;
  assign sensor_fault = 1'b0;
`endif

endmodule

// File: tb/tb_farm_sensor_cond.sv
// Directed bench for farm_sensor_cond (DEBOUNCE_CYCLES=4, CNT_W=3, STUCK_CYCLES=20).
module tb_farm_sensor_cond;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sensor_raw;
  logic       farm_green;
  logic       car_req;
  logic       car_pulse;
  logic [2:0] car_count;
  logic       overflow;
  logic       sensor_fault;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int exp_pulses;
  logic exp_fault;

  farm_sensor_cond #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .STUCK_CYCLES(20)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_raw   (sensor_raw),
    .farm_green   (farm_green),
    .car_req      (car_req),
    .car_pulse    (car_pulse),
    .car_count    (car_count),
    .overflow     (overflow),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && car_pulse) pulses++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic car_arrive();
    sensor_raw = 1'b1;
    tick(8);
    sensor_raw = 1'b0;
    tick(8);
  endtask

  initial begin
`ifdef SENSOR_STUCK_DET_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    rst_n = 1'b0; sensor_raw = 1'b0; farm_green = 1'b0;
    tick(2);
    check("rst_count", 32'(car_count), 0);
    check("rst_req", 32'(car_req), 0);
    check("rst_pulse", 32'(car_pulse), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_fault", 32'(sensor_fault), 0);
    rst_n = 1'b1;
    tick(1);

    // clean arrival: raw high before edge N, arrival on edge N+5
    sensor_raw = 1'b1;
    tick(5);
    check("pre_pulse", 32'(car_pulse), 0);
    check("pre_count", 32'(car_count), 0);
    tick(1);
    check("arr_pulse", 32'(car_pulse), 1);
    check("arr_count", 32'(car_count), 1);
    check("arr_req", 32'(car_req), 1);
    tick(1);
    check("pulse_one_cycle", 32'(car_pulse), 0);
    tick(3);
    sensor_raw = 1'b0;
    tick(12);
    check("release_pulses", 32'(pulses), 1);
    check("release_count", 32'(car_count), 1);

    // 3-cycle high glitch
    sensor_raw = 1'b1;
    tick(3);
    sensor_raw = 1'b0;
    tick(10);
    check("glitch_pulses", 32'(pulses), 1);
    check("glitch_count", 32'(car_count), 1);

    // 3-cycle low dip inside a high period
    sensor_raw = 1'b1;
    tick(8);
    sensor_raw = 1'b0;
    tick(3);
    sensor_raw = 1'b1;
    tick(6);
    sensor_raw = 1'b0;
    tick(10);
    check("dip_pulses", 32'(pulses), 2);
    check("dip_count", 32'(car_count), 2);

    // grant clears the queue
    car_arrive();
    check("pre_grant_count", 32'(car_count), 3);
    farm_green = 1'b1;
    tick(1);
    check("grant_count", 32'(car_count), 0);
    check("grant_req", 32'(car_req), 0);
    check("grant_ovf", 32'(overflow), 0);
    exp_pulses = pulses + 1;
    car_arrive();
    check("green_arr_pulse", 32'(pulses), 32'(exp_pulses));
    check("green_arr_count", 32'(car_count), 0);
    farm_green = 1'b0;
    tick(1);
    car_arrive();
    check("post_grant_count", 32'(car_count), 1);
    check("post_grant_req", 32'(car_req), 1);

    // saturation at 7
    repeat (6) car_arrive();
    check("sat7_count", 32'(car_count), 7);
    check("sat7_ovf", 32'(overflow), 0);
    car_arrive();
    check("sat8_count", 32'(car_count), 7);
    check("sat8_ovf", 32'(overflow), 1);
    exp_pulses = pulses + 1;
    car_arrive();
    check("sat9_count", 32'(car_count), 7);
    check("sat9_ovf", 32'(overflow), 1);
    check("sat9_pulse", 32'(pulses), 32'(exp_pulses));

    // reset during CHK_HI
    sensor_raw = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("midrst_count", 32'(car_count), 0);
    check("midrst_ovf", 32'(overflow), 0);
    check("midrst_req", 32'(car_req), 0);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("restart_pre_pulse", 32'(car_pulse), 0);
    check("restart_pre_count", 32'(car_count), 0);
    tick(1);
    check("restart_pulse", 32'(car_pulse), 1);
    check("restart_count", 32'(car_count), 1);

    // held high well beyond STUCK_CYCLES
    tick(40);
    check("stuck_fault", 32'(sensor_fault), 32'(exp_fault));
    farm_green = 1'b1;
    tick(1);
    check("stuck_green_count", 32'(car_count), 0);
    check("stuck_green_req", 32'(car_req), 32'(exp_fault));
    sensor_raw = 1'b0;
    farm_green = 1'b0;
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
